// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and unified-memory signals around mem_arbiter.
// slave is the arbiter's view; master is the caches-plus-memory side.
interface mem_arbiter_if #(
    parameter int LINE_W = 64
);
    logic              i_req;
    logic [15:0]       i_addr;
    logic              i_rdy;
    logic              d_req;
    logic              d_we;
    logic [15:0]       d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_rdy;
    logic [LINE_W-1:0] rd_data;
    logic              mem_re;
    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdy, d_rdy, rd_data, mem_re, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdy, d_rdy, rd_data, mem_re, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between I-cache fills
// and D-cache fills/writebacks.
//
//   state  | meaning
//   IDLE   | sample requests, grant one and latch its command
//   ACCESS | memory strobe held for MEM_LAT cycles, read data captured on the last
//   RESP   | one-cycle rdy pulse to the granted requester
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int LINE_W  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lastGnt;
    logic              gntD;
    logic              memRe;
    logic              memWe;
    logic [15:0]       memAddr;
    logic [LINE_W-1:0] memWdata;
    logic [LINE_W-1:0] rdData;
    logic              iRdy;
    logic              dRdy;
    logic              busyQ;
    logic              pickD;

    // D wins when it is alone, or on a tie when I was served last.
    assign pickD = bus.d_req && (!bus.i_req || (lastGnt == GNT_I));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lastGnt  <= GNT_I;
            gntD     <= 1'b0;
            memRe    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            rdData   <= '0;
            iRdy     <= 1'b0;
            dRdy     <= 1'b0;
            busyQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        gntD     <= pickD;
                        lastGnt  <= pickD ? GNT_D : GNT_I;
                        memAddr  <= pickD ? bus.d_addr : bus.i_addr;
                        memWdata <= pickD ? bus.d_wdata : '0;
                        memRe    <= pickD ? !bus.d_we : 1'b1;
                        memWe    <= pickD && bus.d_we;
                        cnt      <= CNT_W'(MEM_LAT - 1);
                        busyQ    <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (memRe) begin
                            rdData <= bus.mem_rdata;
                        end
                        memRe <= 1'b0;
                        memWe <= 1'b0;
                        iRdy  <= !gntD;
                        dRdy  <= gntD;
                        state <= RESP;
                    end
                end
                RESP: begin
                    iRdy  <= 1'b0;
                    dRdy  <= 1'b0;
                    busyQ <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_re    = memRe;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.rd_data   = rdData;
    assign bus.i_rdy     = iRdy;
    assign bus.d_rdy     = dRdy;
    assign bus.busy      = busyQ;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified-memory port between the instruction cache (read-only line fills) and the data cache (line fills and dirty writebacks). It sits between both caches and the memory model, where stalled fetch and MEM stages resolve misses. A fixed-latency memory is sequenced through a small FSM, and simultaneous requesters are served round-robin so neither stage can starve.

## Interface
- MEM_LAT, 4, memory access latency in cycles; legal range ≥1.
- LINE_W, 64, cache-line width in bits.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache line-read request; held until i_rdy.
- i_addr  in  16  I-cache line address.
- i_rdy  out  1  one-cycle pulse: I read complete, rd_data valid.
- d_req  in  1  D-cache request; held until d_rdy.
- d_we  in  1  1 = writeback (write), 0 = fill (read).
- d_addr  in  16  D-cache line address.
- d_wdata  in  LINE_W  writeback data.
- d_rdy  out  1  one-cycle pulse: D access complete; rd_data valid if read.
- rd_data  out  LINE_W  read data returned to the granted requester.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data; valid in the last strobe cycle.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: requests are sampled.
  - If neither request is high, remain in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not recorded in last_gnt.
  - On grant: latch the command into mem_addr, mem_wdata, mem_re and mem_we; load cnt = MEM_LAT-1; set last_gnt to the winner; go to ACCESS.
- ACCESS: hold mem_* stable.
  - If cnt ≠ 0, decrement cnt.
  - If cnt = 0: capture mem_rdata into rd_data (reads only), clear mem_re and mem_we, and go to RESP.
- RESP: pulse the granted requester's rdy for exactly one cycle, then go to IDLE. Requests are ignored in RESP.
- An I grant always drives mem_re=1 and mem_we=0.
- A D grant drives mem_we=d_we and mem_re=!d_we.
- mem_re and mem_we are never high together.
- Requests are sampled only in IDLE. Changes to req, addr or data during ACCESS or RESP have no effect. A withdrawn request still completes and still receives its rdy pulse.
- rd_data holds its last captured value until the next read capture; writes do not modify it.
- last_gnt resets to I, so the first tie goes to D.
- cnt width is $clog2(MEM_LAT)+1, enough to hold MEM_LAT-1 without wrap.
- Reset (asynchronous, at any time, including mid-ACCESS):
  - state = IDLE, cnt = 0, last_gnt = I.
  - All outputs 0: mem_re, mem_we, mem_addr, mem_wdata, i_rdy, d_rdy, rd_data, busy.
  - The aborted transaction produces no rdy pulse.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Request first sampled high in IDLE at the edge ending cycle 0:
  - mem_* strobes are high in cycles 1..MEM_LAT;
  - mem_rdata is sampled at the edge ending cycle MEM_LAT;
  - rdy is high in cycle MEM_LAT+1;
  - the block is in IDLE in cycle MEM_LAT+2.
- Request-to-rdy latency is MEM_LAT+1 cycles. Minimum spacing between consecutive grants is MEM_LAT+2 cycles.
- Requester protocol: drop req in the cycle after rdy is seen, i.e. while the arbiter is in IDLE, or keep it high to request again. A req still high in IDLE starts a new transaction.
- Both requests held high continuously: grants alternate D, I, D, I, …
- MEM_LAT=1: strobe for one cycle, rdy two cycles after the sampling edge.

## Test plan
- I read only (MEM_LAT=4): i_req=1, i_addr=0x0040, mem_rdata=0x1122334455667788 in cycle 4.
  - Expect mem_re=1 and mem_addr=0x0040 in cycles 1–4; i_rdy=1 only in cycle 5 with rd_data=0x1122334455667788; d_rdy=0; busy cycles 1–5.
- D writeback: d_req=1, d_we=1, d_addr=0x0100, d_wdata=0xDEADBEEFCAFEF00D.
  - Expect mem_we=1 in cycles 1–4, mem_re=0, mem_wdata matching d_wdata, d_rdy in cycle 5; rd_data unchanged.
- Simultaneous first requests (i_addr=0x0010, d_addr=0x0200) after reset.
  - Expect D served first (mem_addr=0x0200, d_rdy in cycle 5), then I granted in cycle 6 (mem_re cycles 7–10, i_rdy in cycle 11).
- Both requests held high for 4 transactions.
  - Expect grant order D, I, D, I; rdy pulses exactly 6 cycles apart; never both rdy in one cycle.
- rst_n pulled low in cycle 2 of a D read, released in cycle 3.
  - Expect all outputs 0 immediately with no d_rdy pulse; the next request behaves as a fresh post-reset grant (D wins a tie).
- MEM_LAT=1 build, single I read.
  - Expect mem_re only in cycle 1 and i_rdy in cycle 2; i_req dropped during ACCESS still yields i_rdy.
